// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..modulus-1 (at least one bit).
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: passes one tick for every PRESCALE cycles with en_in high.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en_in,
  output logic tick_out
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] phase_q, phase_d;

  assign tick_out = en_in && (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (restart)       phase_d = '0;
    else if (tick_out) phase_d = '0;
    else if (en_in)    phase_d = phase_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) phase_q <= '0;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with wrap/saturate mode, clear, load and status pulses.
// Define COUNTER_PRESCALE_EN to divide the step enable by PRESCALE.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             load_err
);
  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MAX = W1'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE = W1'(1);

  if (WIDTH < 1 || MODULUS < 2 || cnt_width(MODULUS) > WIDTH) begin : g_bad_params
    $error("mod_updown_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d, sat_q, sat_d, lerr_q, lerr_d;
  logic             step;
  logic [WIDTH:0]   cur, inc, dec, ld;
  dir_e             dir;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (clear | load),
    .en_in   (en),
    .tick_out(step)
  );
`else
  assign step = en;
`endif

  assign dir = dir_e'(up);
  assign cur = {1'b0, count_q};
  assign inc = cur + ONE;
  assign dec = cur - ONE;
  assign ld  = {1'b0, load_val};

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    lerr_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      sat_d = 1'b0;
      if (ld > MAX) begin
        count_d = MAX[WIDTH-1:0];
        lerr_d  = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (step) begin
      sat_d = 1'b0;
      if (dir == DIR_UP) begin
        if (cur == MAX) begin
          if (SATURATE == MODE_SAT) sat_d = 1'b1;
          else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = inc[WIDTH-1:0];
        end
      end else begin
        if (cur == '0) begin
          if (SATURATE == MODE_SAT) sat_d = 1'b1;
          else begin
            count_d = MAX[WIDTH-1:0];
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = lerr_q;

endmodule
